// File: rtl/player_gun.sv
// player_gun: ship column, multi-slot bullets and saturating BCD score.
// Ports: clk, reset(n), clear, buttons, ScoreClear, Enable, hit -> ship/bullets/score.
module player_gun #(
  parameter int COLS         = 32,
  parameter int ROWS         = 16,
  parameter int NBULLETS     = 4,
  parameter int SCORE_DIGITS = 2,
  parameter int POINTS       = 1,
  localparam int XW = $clog2(COLS),
  localparam int YW = $clog2(ROWS),
  localparam int SW = 4 * SCORE_DIGITS
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   left,
  input  logic                   right,
  input  logic                   shoot,
  input  logic                   start,
  input  logic                   ScoreClear,
  input  logic                   Enable,
  input  logic [NBULLETS-1:0]    hit,
  output logic [XW-1:0]          posShip,
  output logic                   startPulse,
  output logic [NBULLETS*XW-1:0] bulletX,
  output logic [NBULLETS*YW-1:0] bulletY,
  output logic [NBULLETS-1:0]    BulletActive,
  output logic [SW-1:0]          Score
);

  // {start, shoot, right, left}
  logic [3:0] hist;
  logic [3:0] btn;
  logic [3:0] edg;

  logic [XW-1:0] pos_q, pos_d;
  logic          sp_q;
  logic [SW-1:0] score_q, score_d;

  logic [XW-1:0] bx_q [NBULLETS];
  logic [YW-1:0] by_q [NBULLETS];
  logic [XW-1:0] bx_d [NBULLETS];
  logic [YW-1:0] by_d [NBULLETS];
  logic [NBULLETS-1:0] act_q, act_d;
  logic [NBULLETS-1:0] load;
  logic                found;

  assign btn = {start, shoot, right, left};
  assign edg = btn & ~hist;

  // Adds p to a BCD value; any carry out of the top digit pins it at all nines.
  function automatic logic [SW-1:0] bcd_add(
    input logic [SW-1:0] s,
    input logic [3:0]    p
  );
    logic [4:0]    d;
    logic [3:0]    c;
    logic [SW-1:0] r;
    c = p;
    r = s;
    for (int i = 0; i < SCORE_DIGITS; i++) begin
      d = {1'b0, s[i*4 +: 4]} + {1'b0, c};
      if (d > 5'd9) begin
        r[i*4 +: 4] = 4'(d - 5'd10);
        c = 4'd1;
      end else begin
        r[i*4 +: 4] = d[3:0];
        c = 4'd0;
      end
    end
    if (c != 4'd0) r = {SCORE_DIGITS{4'h9}};
    return r;
  endfunction

  always_comb begin
    pos_d = pos_q;
    if (clear) begin
      pos_d = XW'(COLS / 2);
    end else if (edg[0] && !edg[1]) begin
      if (pos_q != '0) pos_d = pos_q - 1'b1;
    end else if (edg[1] && !edg[0]) begin
      if (pos_q != XW'(COLS - 1)) pos_d = pos_q + 1'b1;
    end
  end

  // Free-slot search runs on the pre-edge flags, so a slot freed
  // this cycle is not reusable until the next one.
  always_comb begin
    load  = '0;
    found = 1'b0;
    for (int i = 0; i < NBULLETS; i++) begin
      if (!act_q[i] && !found) begin
        load[i] = edg[2];
        found   = 1'b1;
      end
    end
  end

  always_comb begin
    score_d = score_q;
    act_d   = act_q;
    for (int i = 0; i < NBULLETS; i++) begin
      bx_d[i] = bx_q[i];
      by_d[i] = by_q[i];
      if (load[i]) begin
        bx_d[i]  = pos_q;
        by_d[i]  = YW'(ROWS - 2);
        act_d[i] = 1'b1;
      end else if (act_q[i] && hit[i]) begin
        act_d[i] = 1'b0;
        score_d  = bcd_add(score_d, 4'(POINTS));
      end else if (act_q[i] && Enable) begin
        if (by_q[i] != '0) by_d[i] = by_q[i] - 1'b1;
        else act_d[i] = 1'b0;
      end
    end
    if (clear) begin
      score_d = score_q;
      act_d   = '0;
      for (int i = 0; i < NBULLETS; i++) begin
        bx_d[i] = '0;
        by_d[i] = '0;
      end
    end
    if (ScoreClear) score_d = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist    <= '0;
      pos_q   <= XW'(COLS / 2);
      sp_q    <= 1'b0;
      score_q <= '0;
      act_q   <= '0;
      for (int i = 0; i < NBULLETS; i++) begin
        bx_q[i] <= '0;
        by_q[i] <= '0;
      end
    end else begin
      hist    <= btn;
      pos_q   <= pos_d;
      sp_q    <= edg[3];
      score_q <= score_d;
      act_q   <= act_d;
      for (int i = 0; i < NBULLETS; i++) begin
        bx_q[i] <= bx_d[i];
        by_q[i] <= by_d[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NBULLETS; i++) begin
      bulletX[i*XW +: XW] = bx_q[i];
      bulletY[i*YW +: YW] = by_q[i];
    end
  end

  assign posShip      = pos_q;
  assign startPulse   = sp_q;
  assign BulletActive = act_q;
  assign Score        = score_q;

endmodule

// File: doc/player_gun.md
# player_gun

Parametrised successor to the single-shot player block: it tracks the ship's column and manages up to NBULLETS simultaneous bullets, each with its own position and active flag. It accumulates a saturating BCD score from per-bullet hit reports. The block sits between the debounced button inputs and the collision/render logic. Field size, bullet count, score digits and points per hit are all parameters.

## Interface
- COLS, 32, field width in columns; XW = clog2(COLS)
- ROWS, 16, field height in rows; YW = clog2(ROWS); row 0 is the top, row ROWS-1 is the ship row
- NBULLETS, 4, number of bullet slots (1..8)
- SCORE_DIGITS, 2, BCD digits of score
- POINTS, 1, points added per hit, 1..9
- clk  in  1  system clock, all state updates on its rising edge
- reset  in  1  asynchronous, active-low reset
- clear  in  1  synchronous game clear (ship recentred, all bullets killed)
- left, right, shoot, start  in  1 each  debounced button levels; only rising edges act
- ScoreClear  in  1  synchronous score clear
- Enable  in  1  game tick; bullets advance only on cycles where it is 1
- hit  in  NBULLETS  per-slot hit report from collision logic
- posShip  out  XW  ship column
- startPulse  out  1  one-cycle pulse on rising edge of start
- bulletX  out  NBULLETS*XW  packed bullet columns, slot i at [i*XW +: XW]
- bulletY  out  NBULLETS*YW  packed bullet rows, slot i at [i*YW +: YW]
- BulletActive  out  NBULLETS  per-slot active flag
- Score  out  4*SCORE_DIGITS  BCD score, least-significant digit in [3:0]

## Operation
- Edge detect: each of left/right/shoot/start has a history register. An edge is present on a cycle where input=1 and history=0. History always loads the input.
- Ship movement:
  - left edge: posShip-1 if posShip>0, else hold.
  - right edge: posShip+1 if posShip<COLS-1, else hold.
  - left and right edges on the same cycle: hold.
  - Movement is not gated by Enable.
- Fire: on a shoot edge, the lowest-index slot with BulletActive=0 (evaluated on pre-edge state) is loaded with X=posShip (pre-edge value), Y=ROWS-2, active=1. If no slot is free, the shot is dropped silently. A slot freed on the same cycle cannot be reused that cycle.
- Advance: on Enable, every active slot not hit and not newly loaded this cycle does the following:
  - Y>0: Y decrements.
  - Y==0: slot deactivates (bullet leaves the top of the field). No score is awarded.
- Hit:
  - hit[i] with slot i active: slot i deactivates and score += POINTS.
  - hit[i] on an inactive slot: ignored.
  - hit takes priority over advance.
  - k simultaneous valid hits add k*POINTS in that cycle.
- Score is BCD with SCORE_DIGITS digits. It saturates at all nines and never wraps.
- ScoreClear sets Score to 0 and overrides any hits in the same cycle.
- clear:
  - posShip = COLS/2.
  - All BulletActive = 0; bulletX/bulletY = 0.
  - Overrides move, fire, advance and hit in the same cycle.
  - Score and edge histories are unaffected.
- Inactive slots keep their last X/Y. Downstream logic must qualify positions with BulletActive.

## Timing
- Reset (reset=0, asynchronous):
  - posShip = COLS/2 (16 by default).
  - bulletX, bulletY, BulletActive, Score, startPulse = 0.
  - All edge histories = 0.
- Reset asserted mid-flight clears everything immediately, with no clock needed. Release is sampled at the next rising clk.
- All outputs are registered. Effects of a button edge, hit, Enable, clear or ScoreClear present at rising edge n are visible on outputs after edge n, i.e. one-cycle latency.
- startPulse is high for exactly one cycle per start rising edge. A held start produces no further pulses.
- A button held high for many cycles acts once. Release and re-press is required for another action.
- Priority within a cycle: reset > clear > (hit > advance) for bullets. ScoreClear > hit for score.

## Test plan
- Reset then release -> posShip=16, BulletActive=0000, Score=0x00, startPulse=0.
- Left pressed 20 times from 16, each press 1 cycle high and 1 low -> posShip stops at 0. Right pressed 40 times -> posShip stops at 31. Left and right rising together -> no change.
- Ship at 10, four shoot edges without Enable -> slots 0..3 active, all X=10, Y=14. Fifth shoot -> dropped, BulletActive=1111.
- One bullet at Y=14 with Enable held high -> Y reaches 0 after 14 ticks, BulletActive clears on the 15th tick, Score unchanged.
- POINTS=1, Score=0x97: hit=1011 on slots 0,1,3 all active -> Score=0x99 saturated (100 not representable), slots 0,1,3 inactive. hit on an inactive slot -> no score change.
- Same cycle: ScoreClear plus hit[0] on active slot 0 -> Score=0x00, slot 0 inactive. clear with Enable and shoot edge -> posShip=16, no bullets active. Async reset mid-flight -> all outputs at reset values before the next clk.
